// File: rtl/satd_pkg.sv
// Shared types and helpers for the SATD residual / reconstruction path.
//   LANES  - samples per row
//   ROWS   - rows per block
//   PIX_W  - pixel width; residuals are PIX_W+1 bits signed, sums PIX_W+2 bits signed
package satd_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned ROWS   = 8;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned RES_W  = PIX_W + 1;
  localparam int unsigned SUM_W  = PIX_W + 2;
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned CLIP_W = $clog2(LANES * ROWS) + 1;
  localparam int unsigned LCNT_W = $clog2(LANES) + 1;

  typedef logic        [PIX_W-1:0] pix_t;
  typedef logic signed [RES_W-1:0] res_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  typedef pix_t [LANES-1:0] pix_row_t;
  typedef res_t [LANES-1:0] res_row_t;
  typedef sum_t [LANES-1:0] sum_row_t;

  // Stage-1 payload: unclipped sums plus positional tags.
  typedef struct packed {
    sum_row_t         sum;
    logic [ROW_W-1:0] row;
    logic             last;
  } s1_pay_t;

  // Saturate a signed sum into the pixel range [0, 2^PIX_W-1].
  function automatic pix_t clip_pix(input sum_t s);
    if (s[SUM_W-1]) begin
      return '0;
    end else if (s[SUM_W-2:PIX_W] != '0) begin
      return '1;
    end else begin
      return s[PIX_W-1:0];
    end
  endfunction

  // True when clip_pix would alter the value.
  function automatic logic clip_hit(input sum_t s);
    return s[SUM_W-1] | (s[SUM_W-2:PIX_W] != '0);
  endfunction

endpackage

// File: rtl/recon_lane.sv
// Per-lane combinational arithmetic for reconstruction.
//   pred, res -> sum_c          : zero-extended pred plus sign-extended res
//   sum       -> pix_c, clip_c  : saturated pixel and a flag set when saturation occurred
// The add and the clip are used in different pipeline stages, so they are
// kept as two independent paths through the same lane instance.
module recon_lane
  import satd_pkg::*;
(
  input  pix_t pred,
  input  res_t res,
  output sum_t sum_c,
  input  sum_t sum,
  output pix_t pix_c,
  output logic clip_c
);

  // Range -2^PIX_W .. 2^(PIX_W+1)-2 always fits SUM_W signed bits.
  assign sum_c  = $signed(SUM_W'(pred)) + SUM_W'(res);
  assign pix_c  = clip_pix(sum);
  assign clip_c = clip_hit(sum);

endmodule

// File: rtl/recon_row.sv
// Row reconstruction: REC = clip(PRED + RES, 0, 2^PIX_W-1), LANES samples per beat.
// Two-stage valid/ready pipeline (S1 = sum, S2 = clip/output), positional
// row counter tagging OUT_ROW / OUT_LAST, and a per-block clipped-sample count.
//   CLK, RST_N           clock, async active-low reset
//   IN_VALID / IN_READY  input handshake; PRED, RES carry the row
//   OUT_VALID/OUT_READY  output handshake; REC, OUT_ROW, OUT_LAST carry the row
//   CLIP_CNT, CLIP_VALID clipped-sample total of the last completed block, 1-cycle update pulse
module recon_row
  import satd_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  pix_row_t          PRED,
  input  res_row_t          RES,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output pix_row_t          REC,
  output logic [ROW_W-1:0]  OUT_ROW,
  output logic              OUT_LAST,
  output logic [CLIP_W-1:0] CLIP_CNT,
  output logic              CLIP_VALID
);

  logic              s1_valid;
  s1_pay_t           s1;
  logic              out_valid;
  pix_row_t          rec;
  logic [ROW_W-1:0]  out_row;
  logic              out_last;
  logic [LCNT_W-1:0] out_clips;
  logic [ROW_W-1:0]  row_cnt;
  logic [CLIP_W-1:0] clip_acc;
  logic [CLIP_W-1:0] clip_cnt;
  logic              clip_valid;

  sum_row_t          lane_sum;
  pix_row_t          lane_pix;
  logic [LANES-1:0]  lane_clip;
  logic [LCNT_W-1:0] row_clips;

  logic in_ready;
  logic accept;
  logic s2_load;
  logic out_fire;
  logic row_is_last;

  // Lane datapath: add feeds S1, clip reads S1.
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    recon_lane u_lane (
      .pred   (PRED[i]),
      .res    (RES[i]),
      .sum_c  (lane_sum[i]),
      .sum    (s1.sum[i]),
      .pix_c  (lane_pix[i]),
      .clip_c (lane_clip[i])
    );
  end

  // Popcount of the lanes clipped in the row currently leaving S1.
  always_comb begin
    row_clips = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      row_clips = row_clips + LCNT_W'(lane_clip[i]);
    end
  end

  // Handshake: S2 takes S1 when the output is empty or draining; S1 refills under the same rule.
  // Gating with RST_N keeps IN_READY low for the whole reset window.
  assign in_ready    = RST_N & (~s1_valid | ~out_valid | OUT_READY);
  assign accept      = IN_VALID & in_ready;
  assign s2_load     = s1_valid & (~out_valid | OUT_READY);
  assign out_fire    = out_valid & OUT_READY;
  assign row_is_last = (row_cnt == ROW_W'(ROWS - 1));

  // Stage 1: sums and positional tags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      row_cnt  <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1.sum   <= lane_sum;
        s1.row   <= row_cnt;
        s1.last  <= row_is_last;
        row_cnt  <= row_is_last ? '0 : row_cnt + ROW_W'(1);
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: clipped row held stable until the sink takes it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      rec       <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
      out_clips <= '0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        rec       <= lane_pix;
        out_row   <= s1.row;
        out_last  <= s1.last;
        out_clips <= row_clips;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Clip accounting on output transfers; the last row publishes and restarts the block total.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clip_acc   <= '0;
      clip_cnt   <= '0;
      clip_valid <= 1'b0;
    end else begin
      clip_valid <= 1'b0;
      if (out_fire) begin
        if (out_last) begin
          clip_cnt   <= clip_acc + CLIP_W'(out_clips);
          clip_valid <= 1'b1;
          clip_acc   <= '0;
        end else begin
          clip_acc   <= clip_acc + CLIP_W'(out_clips);
        end
      end
    end
  end

  assign IN_READY   = in_ready;
  assign OUT_VALID  = out_valid;
  assign REC        = rec;
  assign OUT_ROW    = out_row;
  assign OUT_LAST   = out_last;
  assign CLIP_CNT   = clip_cnt;
  assign CLIP_VALID = clip_valid;

endmodule

// File: tb/tb_recon_row.sv
// Directed bench for recon_row with a reference scoreboard.
module tb_recon_row;
  import satd_pkg::*;

  logic              CLK;
  logic              RST_N;
  logic              IN_VALID;
  logic              IN_READY;
  pix_row_t          PRED;
  res_row_t          RES;
  logic              OUT_VALID;
  logic              OUT_READY;
  pix_row_t          REC;
  logic [ROW_W-1:0]  OUT_ROW;
  logic              OUT_LAST;
  logic [CLIP_W-1:0] CLIP_CNT;
  logic              CLIP_VALID;

  recon_row dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .PRED       (PRED),
    .RES        (RES),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .REC        (REC),
    .OUT_ROW    (OUT_ROW),
    .OUT_LAST   (OUT_LAST),
    .CLIP_CNT   (CLIP_CNT),
    .CLIP_VALID (CLIP_VALID)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    pix_row_t rec;
    int       row;
    bit       last;
    int       clips;
  } exp_t;

  exp_t exp_q[$];
  int   clip_hist[$];
  int   checks, errors;
  int   model_row, model_acc, pend_cnt;
  bit   pend;
  int   n_acc, n_fire;

  // Clipping vector: five of eight lanes saturate.
  int cp[LANES] = '{0, 255, 128, 5, 250, 1, 0, 255};
  int cr[LANES] = '{-1, 1, -128, -10, 10, -256, 255, -255};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load_clip_row();
    for (int i = 0; i < int'(LANES); i++) begin
      PRED[i] = PIX_W'(cp[i]);
      RES[i]  = RES_W'(cr[i]);
    end
  endtask

  task automatic load_rand_row();
    for (int i = 0; i < int'(LANES); i++) begin
      PRED[i] = PIX_W'($urandom);
      RES[i]  = RES_W'($urandom);
    end
  endtask

  // Reference: integer add and saturate of whatever is on PRED/RES now.
  function automatic exp_t ref_row();
    exp_t e;
    int   s;
    e.clips = 0;
    for (int i = 0; i < int'(LANES); i++) begin
      s = int'(PRED[i]) + int'($signed(RES[i]));
      if (s < 0) begin
        e.rec[i] = '0;
        e.clips++;
      end else if (s > 255) begin
        e.rec[i] = PIX_W'(255);
        e.clips++;
      end else begin
        e.rec[i] = PIX_W'(s);
      end
    end
    e.row  = model_row;
    e.last = (model_row == int'(ROWS) - 1);
    return e;
  endfunction

  // One clock: inputs already driven; evaluate handshakes, advance, sample after the edge.
  task automatic tick();
    exp_t e;
    bit   acc, fire;
    #1;
    acc  = IN_VALID && IN_READY;
    fire = OUT_VALID && OUT_READY;
    if (fire) begin
      n_fire++;
      chk("out_has_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rec", 64'(REC), 64'(e.rec));
        chk("out_row", 64'(OUT_ROW), 64'(e.row));
        chk("out_last", 64'(OUT_LAST), 64'(e.last));
        model_acc += e.clips;
        if (e.last) begin
          pend      = 1'b1;
          pend_cnt  = model_acc;
          model_acc = 0;
        end
      end
    end
    if (acc) begin
      exp_q.push_back(ref_row());
      model_row = (model_row + 1) % int'(ROWS);
      n_acc++;
    end
    @(posedge CLK);
    #1;
    chk("clip_valid", 64'(CLIP_VALID), 64'(pend));
    if (pend) chk("clip_cnt", 64'(CLIP_CNT), 64'(pend_cnt));
    if (CLIP_VALID) clip_hist.push_back(int'(CLIP_CNT));
    pend = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_out_valid"}, 64'(OUT_VALID), 64'(0));
    chk({pfx, "_clip_valid"}, 64'(CLIP_VALID), 64'(0));
    chk({pfx, "_out_last"}, 64'(OUT_LAST), 64'(0));
    chk({pfx, "_out_row"}, 64'(OUT_ROW), 64'(0));
    chk({pfx, "_rec"}, 64'(REC), 64'(0));
    chk({pfx, "_clip_cnt"}, 64'(CLIP_CNT), 64'(0));
    chk({pfx, "_in_ready"}, 64'(IN_READY), 64'(0));
  endtask

  initial begin
    pix_row_t rec_hold;
    int       a0, t, cyc;

    checks = 0; errors = 0;
    model_row = 0; model_acc = 0; pend = 1'b0; pend_cnt = 0;
    n_acc = 0; n_fire = 0;
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    PRED = '0; RES = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("rst");
    RST_N = 1'b1;
    #1;
    chk("rst_release_in_ready", 64'(IN_READY), 64'(1));

    // Zero residual passes PRED through with 2-cycle latency
    IN_VALID = 1'b1; OUT_READY = 1'b1; RES = '0;
    for (int i = 0; i < int'(LANES); i++) PRED[i] = PIX_W'(10 * (i + 1));
    tick();
    chk("lat_s1_out_valid", 64'(OUT_VALID), 64'(0));
    IN_VALID = 1'b0;
    tick();
    chk("lat_s2_out_valid", 64'(OUT_VALID), 64'(1));
    chk("pass_rec", 64'(REC), 64'h5046_3C32_281E_140A);
    chk("pass_row", 64'(OUT_ROW), 64'(0));
    chk("pass_last", 64'(OUT_LAST), 64'(0));
    chk("pass_clip_cnt", 64'(CLIP_CNT), 64'(0));

    // Clipping lanes
    IN_VALID = 1'b1;
    load_clip_row();
    tick();
    IN_VALID = 1'b0;
    tick();
    chk("clip_rec", 64'(REC), 64'h00FF_00FF_0000_FF00);
    chk("clip_row", 64'(OUT_ROW), 64'(1));

    // Finish block 0 (35 clips), a full clipping block 1 (40), then row 0 of block 2
    IN_VALID = 1'b1;
    a0 = n_acc;
    t  = 0;
    while (n_acc - a0 < 15 && t < 100) begin
      tick();
      t++;
    end
    IN_VALID = 1'b0;
    repeat (4) tick();
    chk("blk_accepts", 64'(n_acc - a0), 64'(15));
    chk("blk_pulses", 64'(clip_hist.size()), 64'(2));
    chk("blk0_clip_cnt", 64'(clip_hist.size() > 0 ? clip_hist[0] : -1), 64'(35));
    chk("blk1_clip_cnt", 64'(clip_hist.size() > 1 ? clip_hist[1] : -1), 64'(40));
    chk("blk_drained", 64'(exp_q.size()), 64'(0));

    // Back-pressure: two rows buffered, then stall with output held
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    a0 = n_acc;
    rec_hold = '0;
    for (int k = 0; k < 5; k++) begin
      load_rand_row();
      tick();
      if (k == 1) rec_hold = REC;
      if (k >= 2) begin
        chk("bp_out_valid", 64'(OUT_VALID), 64'(1));
        chk("bp_rec_stable", 64'(REC), 64'(rec_hold));
      end
    end
    chk("bp_accepts", 64'(n_acc - a0), 64'(2));
    chk("bp_in_ready", 64'(IN_READY), 64'(0));
    a0 = n_fire;
    OUT_READY = 1'b1;
    IN_VALID  = 1'b0;
    repeat (4) tick();
    chk("bp_fires", 64'(n_fire - a0), 64'(2));
    chk("bp_drained", 64'(exp_q.size()), 64'(0));

    // Random stress against the scoreboard
    a0  = n_acc;
    cyc = 0;
    while (n_acc - a0 < 1000 && cyc < 20000) begin
      IN_VALID  = 1'($urandom_range(0, 1));
      OUT_READY = 1'($urandom_range(0, 1));
      load_rand_row();
      tick();
      cyc++;
    end
    chk("stress_accepts", 64'(n_acc - a0), 64'(1000));
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (4) tick();
    chk("stress_drained", 64'(exp_q.size()), 64'(0));

    // Reset mid-block with rows in both stages
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    load_clip_row();
    t = 0;
    do begin
      tick();
      t++;
    end while ((model_row != 4 || t < 2) && t < 40);
    chk("pre_rst_row", 64'(model_row), 64'(4));
    chk("pre_rst_out_valid", 64'(OUT_VALID), 64'(1));
    RST_N = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    model_row = 0; model_acc = 0; pend = 1'b0;
    IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    IN_VALID = 1'b1;
    a0 = clip_hist.size();
    for (int k = 0; k < int'(ROWS); k++) begin
      tick();
      if (k == 1) begin
        chk("post_rst_valid", 64'(OUT_VALID), 64'(1));
        chk("post_rst_row0", 64'(OUT_ROW), 64'(0));
      end
    end
    IN_VALID = 1'b0;
    repeat (4) tick();
    chk("post_rst_pulses", 64'(clip_hist.size() - a0), 64'(1));
    chk("post_rst_clip_cnt", 64'(clip_hist.size() > 0 ? clip_hist[clip_hist.size() - 1] : -1), 64'(40));
    chk("post_rst_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/recon_row.md
Name: recon_row

Overview:
- Inverse of the SATD residual path: rebuilds 8-sample pixel rows as REC = clip(PRED + RES, 0, 255).
- RES is the 9-bit two's-complement residual produced by the difference stage (ORG - CUR).
- Streams one row per accepted beat through a 2-stage pipeline with valid/ready on both sides.
- Counts rows to mark block boundaries and reports clipping per block. Sits at the decoder/verification end, consuming residual rows and feeding the reconstructed-row sink.

Parameters:
- LANES, 8, samples per row.
- ROWS, 8, rows per block; tags the last row.
- PIX_W, 8, pixel width; residual width is PIX_W+1.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  input row valid.
- IN_READY  out  1  block can accept a row this cycle.
- PRED  in  LANES x PIX_W  unsigned predictor samples.
- RES  in  LANES x (PIX_W+1)  signed residual samples.
- OUT_VALID  out  1  reconstructed row valid.
- OUT_READY  in  1  sink accepts the row.
- REC  out  LANES x PIX_W  reconstructed samples.
- OUT_ROW  out  clog2(ROWS)  row index of the REC beat.
- OUT_LAST  out  1  REC beat is the final row of a block.
- CLIP_CNT  out  clog2(LANES*ROWS)+1  clipped samples in the last completed block.
- CLIP_VALID  out  1  one-cycle pulse when CLIP_CNT updates.

Behaviour:
- Reset (RST_N low, asynchronous) clears:
  - Outputs: OUT_VALID, CLIP_VALID, OUT_LAST, OUT_ROW, REC and CLIP_CNT all 0.
  - Internal state: both stage-valid bits, the row counter and the clip accumulator all 0.
  - IN_READY is 0 while RST_N is low and 1 on the first cycle after release.
- Reset asserted mid-block discards all in-flight rows. The next accepted row is row 0.
- Stage 1 (S1) on accept (IN_VALID & IN_READY):
  - Registers a 10-bit signed sum per lane: zero-extended PRED + sign-extended RES.
  - Registers the current row index and the last flag (row == ROWS-1).
- Stage 2 (S2):
  - Clips each lane: sum < 0 gives 0; sum > 255 gives 255; otherwise sum[7:0].
  - Registers REC, OUT_ROW and OUT_LAST, and sets OUT_VALID.
- Latency: 2 cycles from accept to OUT_VALID when OUT_READY is held high. Throughput is 1 row/cycle.
- Handshake:
  - A stage advances when the stage ahead of it is empty or is transferring that cycle.
  - IN_READY = !s1_valid | !OUT_VALID | OUT_READY. It depends on registered state and OUT_READY only, never on IN_VALID.
  - While OUT_VALID is high and OUT_READY is low: REC, OUT_ROW and OUT_LAST hold stable; S1 holds; at most 2 rows are buffered; IN_READY drops once S1 is full.
  - An input transfer and an output transfer in the same cycle are both legal and lose no data.
- Row counter:
  - Increments on every input accept and wraps from ROWS-1 to 0.
  - Counter, OUT_ROW and OUT_LAST are purely positional. There is no block-start input.
- Clip accumulation:
  - Adds popcount of the lanes clipped in S2 on each output transfer.
  - On the transfer of the OUT_LAST beat: CLIP_CNT ← total including that beat, CLIP_VALID pulses for 1 cycle, and the accumulator clears to 0.
- Residual range:
  - Nominal range is −255..+255.
  - A residual of −256 is still accepted and clipped normally.
  - Sum range is −256..510, so it fits in 10 signed bits with no overflow.

Decomposition:
- Shared package satd_pkg holds:
  - Constants LANES, ROWS, PIX_W.
  - Typedefs pix_t (PIX_W unsigned), res_t (PIX_W+1 signed), pix_row_t and res_row_t (LANES-wide arrays).
  - Function clip_pix (10-bit signed in, pix_t out).
- One sub-module, recon_lane: a combinational per-lane add/clip with a clip flag output, instantiated LANES times.
- Pipeline registers, handshake and counters stay in recon_row.

Test Plan:
1. Reset then stream: RES all 0, PRED = {10,20,…,80}, OUT_READY = 1 → REC equals PRED exactly 2 cycles after accept; OUT_ROW = 0, OUT_LAST = 0, CLIP_CNT = 0.
2. Clipping lanes: PRED = {0,255,128,5,250,1,0,255}, RES = {−1,+1,−128,−10,+10,−256,+255,−255} → REC = {0,255,0,0,255,0,255,0}; 5 lanes flagged as clipped.
3. Full block of 8 rows using row 2's values on every row → OUT_LAST high only on OUT_ROW = 7; CLIP_VALID pulses once after that beat with CLIP_CNT = 40; the next block starts at OUT_ROW = 0.
4. Back-pressure: OUT_READY low for 5 cycles while IN_VALID stays high → exactly 2 rows accepted, then IN_READY = 0; REC stays stable; after release all rows exit in order with none lost or duplicated.
5. Random stress: IN_VALID/OUT_READY toggling at 50%, 1000 rows, compared against a scoreboard model → every row matches in order with correct OUT_ROW sequence.
6. Reset mid-block: assert RST_N low after row 3 accepted while 2 rows are in flight → outputs 0 immediately (asynchronously); the first row after release is tagged OUT_ROW = 0; the partial clip count is discarded.
